// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand hazard sequencer for the 5-stage MIPS core: drives freeze, bubble and squash.
// Optional performance counters are enabled with `define HAZARD_PERF_COUNTERS_EN.
module hazard_stall_controller #(
    parameter int STALL_CNT_W = 2,
    parameter int PERF_W      = 32
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   EXT_STALL_IN,
    input  logic [5:0]             OpcodeID_IN,
    input  logic [4:0]             IDRegisterRS_IN,
    input  logic [4:0]             IDRegisterRT_IN,
    input  logic                   IDUsesRS_IN,
    input  logic                   IDUsesRT_IN,
    input  logic                   AltPCEnable_IN,
    input  logic [4:0]             writeRDIDEXE,
    input  logic                   writeEnableIDEXE,
    input  logic                   memReadIDEXE,
    input  logic [4:0]             writeRDEXEMEM,
    input  logic                   memReadEXEMEM,
    output logic                   STALL_OUT,
    output logic                   BUBBLE_OUT,
    output logic                   FLUSH_OUT,
    output logic                   STATE_OUT,
    output logic [STALL_CNT_W-1:0] StallsLeft_OUT,
    output logic [PERF_W-1:0]      StallCount_OUT,
    output logic [PERF_W-1:0]      FlushCount_OUT
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic       is_branch;
    logic       mx_rs, mx_rt, mm_rs, mm_rt;
    logic [1:0] n_rs, n_rt, n_req;

    // Stall cycles one source operand needs before forwarding can cover it.
    function automatic logic [1:0] need(input logic br, input logic mx, input logic mm,
                                        input logic ld);
        if (br)
            return mx ? (ld ? 2'd2 : 2'd1) : {1'b0, mm};
        return {1'b0, mx & ld};
    endfunction

    assign is_branch = OpcodeID_IN inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7};

    assign mx_rs = IDUsesRS_IN && (IDRegisterRS_IN != 5'd0) && writeEnableIDEXE
                   && (writeRDIDEXE == IDRegisterRS_IN);
    assign mx_rt = IDUsesRT_IN && (IDRegisterRT_IN != 5'd0) && writeEnableIDEXE
                   && (writeRDIDEXE == IDRegisterRT_IN);
    assign mm_rs = IDUsesRS_IN && (IDRegisterRS_IN != 5'd0) && memReadEXEMEM
                   && (writeRDEXEMEM == IDRegisterRS_IN);
    assign mm_rt = IDUsesRT_IN && (IDRegisterRT_IN != 5'd0) && memReadEXEMEM
                   && (writeRDEXEMEM == IDRegisterRT_IN);

    assign n_rs  = need(is_branch, mx_rs, mm_rs, memReadIDEXE);
    assign n_rt  = need(is_branch, mx_rt, mm_rt, memReadIDEXE);
    assign n_req = (n_rs > n_rt) ? n_rs : n_rt;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!EXT_STALL_IN && n_req > 2'd1) begin
                    state_d = HOLD;
                    cnt_d   = STALL_CNT_W'(n_req - 2'd1);
                end
            end
            HOLD: begin
                // Counter is frozen while memory holds the pipeline; guarded against underflow.
                if (!EXT_STALL_IN) begin
                    if (cnt_q <= STALL_CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - STALL_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        STALL_OUT  = 1'b0;
        BUBBLE_OUT = 1'b0;
        FLUSH_OUT  = 1'b0;
        if (RESET) begin
            if (state_q == HOLD) begin
                STALL_OUT  = 1'b1;
                BUBBLE_OUT = !EXT_STALL_IN;
            end else if (EXT_STALL_IN) begin
                STALL_OUT = 1'b1;
            end else if (n_req != 2'd0) begin
                STALL_OUT  = 1'b1;
                BUBBLE_OUT = 1'b1;
            end else begin
                FLUSH_OUT = AltPCEnable_IN;
            end
        end
    end

    assign STATE_OUT      = state_q;
    assign StallsLeft_OUT = cnt_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (BUBBLE_OUT && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (FLUSH_OUT && !(&flush_cnt_q))  flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign StallCount_OUT = stall_cnt_q;
    assign FlushCount_OUT = flush_cnt_q;
`else
    assign StallCount_OUT = '0;
    assign FlushCount_OUT = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed test-plan scenarios, then random traffic
// checked against a cycle-level reference model.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext;
    logic [5:0]  op;
    logic [4:0]  rs, rt, exrd, memrd;
    logic        urs, urt, alt, exwe, exld, memld;
    logic        stall, bubble, flush, state;
    logic [1:0]  left;
    logic [31:0] scnt, fcnt;

    always #5 clk = ~clk;

    hazard_stall_controller #(.STALL_CNT_W(2), .PERF_W(32)) dut (
        .CLOCK(clk), .RESET(rst_n), .EXT_STALL_IN(ext), .OpcodeID_IN(op),
        .IDRegisterRS_IN(rs), .IDRegisterRT_IN(rt), .IDUsesRS_IN(urs), .IDUsesRT_IN(urt),
        .AltPCEnable_IN(alt), .writeRDIDEXE(exrd), .writeEnableIDEXE(exwe),
        .memReadIDEXE(exld), .writeRDEXEMEM(memrd), .memReadEXEMEM(memld),
        .STALL_OUT(stall), .BUBBLE_OUT(bubble), .FLUSH_OUT(flush), .STATE_OUT(state),
        .StallsLeft_OUT(left), .StallCount_OUT(scnt), .FlushCount_OUT(fcnt)
    );

    typedef struct {
        logic       rst_n, ext, alt, urs, urt, exwe, exld, memld;
        logic [5:0] op;
        logic [4:0] rs, rt, exrd, memrd;
    } stim_t;

    typedef struct {
        logic        stall, bubble, flush, state;
        logic [1:0]  left;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;

    // Reference model state: remaining forced stall cycles and event tallies.
    int          hold_left = 0;
    int unsigned m_bubbles = 0, m_flushes = 0;

    function automatic int op_need(input stim_t s, input logic [4:0] src, input logic uses);
        bit br, in_ex, in_mem;
        br     = (s.op == 1) || (s.op >= 4 && s.op <= 7);
        if (!uses || src == 0) return 0;
        in_ex  = s.exwe && (s.exrd == src);
        in_mem = s.memld && (s.memrd == src);
        if (br) return in_ex ? (s.exld ? 2 : 1) : (in_mem ? 1 : 0);
        return (in_ex && s.exld) ? 1 : 0;
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; ext = s.ext; op = s.op; rs = s.rs; rt = s.rt; urs = s.urs; urt = s.urt;
        alt = s.alt; exrd = s.exrd; exwe = s.exwe; exld = s.exld; memrd = s.memrd; memld = s.memld;
        n = op_need(s, s.rs, s.urs);
        if (op_need(s, s.rt, s.urt) > n) n = op_need(s, s.rt, s.urt);
        e.state = (hold_left > 0);
        e.left  = 2'(hold_left);
`ifdef HAZARD_PERF_COUNTERS_EN
        e.sc = m_bubbles; e.fc = m_flushes;
`else
        e.sc = 0; e.fc = 0;
`endif
        e.stall = 0; e.bubble = 0; e.flush = 0;
        if (!s.rst_n) begin
            hold_left = 0;
        end else if (hold_left > 0) begin
            e.stall = 1; e.bubble = !s.ext;
            if (!s.ext) hold_left--;
        end else if (s.ext) begin
            e.stall = 1;
        end else if (n > 0) begin
            e.stall = 1; e.bubble = 1;
            hold_left = n - 1;
        end else begin
            e.flush = s.alt;
        end
        if (!s.rst_n) begin
            m_bubbles = 0; m_flushes = 0;
        end else begin
            m_bubbles += e.bubble; m_flushes += e.flush;
        end
        q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n:1, ext:0, alt:0, urs:0, urt:0, exwe:0, exld:0, memld:0,
              op:6'd0, rs:5'd0, rt:5'd0, exrd:5'd0, memrd:5'd0};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",  32'(stall),  32'(e.stall));
                chk("bubble", 32'(bubble), 32'(e.bubble));
                chk("flush",  32'(flush),  32'(e.flush));
                chk("state",  32'(state),  32'(e.state));
                chk("left",   32'(left),   32'(e.left));
                chk("stallcnt", scnt, e.sc);
                chk("flushcnt", fcnt, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 0; ext = 0; op = 0; rs = 0; rt = 0; urs = 0; urt = 0; alt = 0;
        exrd = 0; exwe = 0; exld = 0; memrd = 0; memld = 0;

        s = idle(); s.rst_n = 0;
        cyc(s); cyc(s);
        s = idle(); cyc(s);

        // load-use: lw $8 in EX, add reads RS=8
        s = idle(); s.op = 0; s.rs = 8; s.urs = 1; s.exrd = 8; s.exwe = 1; s.exld = 1;
        cyc(s);
        s.exwe = 0; s.exld = 0; cyc(s);

        // beq after load on RT=9 (2 stalls)
        s = idle(); s.op = 4; s.rt = 9; s.urt = 1; s.exrd = 9; s.exwe = 1; s.exld = 1;
        cyc(s);
        s = idle(); s.op = 4; s.rt = 9; s.urt = 1; cyc(s);
        s = idle(); cyc(s);

        // bne after ALU op, taken: stall then flush
        s = idle(); s.op = 5; s.rs = 3; s.urs = 1; s.exrd = 3; s.exwe = 1; s.alt = 1;
        cyc(s);
        s = idle(); s.op = 5; s.rs = 3; s.urs = 1; s.alt = 1; cyc(s);
        s = idle(); cyc(s);

        // register zero never matches
        s = idle(); s.rs = 0; s.urs = 1; s.exrd = 0; s.exwe = 1; s.exld = 1;
        cyc(s);

        // EXT_STALL_IN for 3 cycles during HOLD
        s = idle(); s.op = 1; s.rs = 7; s.urs = 1; s.exrd = 7; s.exwe = 1; s.exld = 1;
        cyc(s);
        s = idle(); s.ext = 1; cyc(s); cyc(s); cyc(s);
        s = idle(); cyc(s); cyc(s);

        // reset during HOLD
        s = idle(); s.op = 6; s.rt = 2; s.urt = 1; s.exrd = 2; s.exwe = 1; s.exld = 1;
        cyc(s);
        s = idle(); s.rst_n = 0; cyc(s);
        s = idle(); cyc(s);

        // random traffic over a tiny register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 39) != 0);
            s.ext   = ($urandom_range(0, 5) == 0);
            s.op    = 6'($urandom_range(0, 9));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom);
            s.urt   = 1'($urandom);
            s.alt   = 1'($urandom);
            s.exrd  = 5'($urandom_range(0, 3));
            s.exwe  = 1'($urandom);
            s.exld  = 1'($urandom);
            s.memrd = 5'($urandom_range(0, 3));
            s.memld = 1'($urandom);
            cyc(s);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        done = 1;
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
